// File: rtl/fsm_bist_pkg.sv
// Shared types, constants and next-state helpers for the FSM BIST controller.
package fsm_bist_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StInit,
      StRun,
      StFlush,
      StDone
   } bist_state_e;

   localparam logic [7:0]  LFSR_TAPS = 8'hB8;
   localparam logic [15:0] MISR_POLY = 16'h1021;
   localparam int unsigned PAT_W     = 4;
   localparam int unsigned SIG_W     = 16;

   // One MISR step: shift, fold the feedback polynomial, absorb the FSM state.
   function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] m,
                                                  input logic [PAT_W-1:0] d);
      logic [SIG_W-1:0] fb;
      fb = m[SIG_W-1] ? MISR_POLY : '0;
      return {m[SIG_W-2:0], 1'b0} ^ fb ^ {{(SIG_W - PAT_W){1'b0}}, d};
   endfunction

   // One Fibonacci LFSR step; taps 7,5,4,3 feed bit 0.
   function automatic logic [7:0] lfsr_step(input logic [7:0] l);
      return {l[6:0], ^(l & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/fsm_bist_misr.sv
// Multiple-input signature register compacting the controlled FSM's state.
module fsm_bist_misr
   import fsm_bist_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [PAT_W-1:0] d,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0] sig_q;

   // Signature register: clear wins over absorb.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sig_q <= '0;
      end else if (clr) begin
         sig_q <= '0;
      end else if (en) begin
         sig_q <= misr_step(sig_q, d);
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/fsm_bist_ctrl.sv
// BIST controller for a 16-state FSM: LFSR stimulus, MISR compaction, pass/fail.
// Optional feature macro: FSM_BIST_CTRL_SIG_READ_EN exposes the final signature
// on bist_sig_o; when undefined the port is tied to zero.
module fsm_bist_ctrl
   import fsm_bist_pkg::*;
#(
   parameter int unsigned N_PAT      = 200,
   parameter logic [7:0]  LFSR_SEED  = 8'h01,
   parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bist_start_i,
   input  logic             bist_abort_i,
   input  logic [PAT_W-1:0] func_sig_i,
   input  logic [PAT_W-1:0] fsm_state_i,
   output logic [PAT_W-1:0] fsm_sig_o,
   output logic             fsm_clr_o,
   output logic             bist_busy_o,
   output logic             bist_done_o,
   output logic             bist_pass_o,
   output logic [SIG_W-1:0] bist_sig_o
);

   // An all-zero seed would lock the LFSR.
   localparam logic [7:0]  Seed    = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
   localparam logic [15:0] LastPat = 16'(N_PAT - 1);

   bist_state_e      state_q;
   logic [7:0]       lfsr_q;
   logic [15:0]      cnt_q;
   logic             clr_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [SIG_W-1:0] misr_sig;
   logic [SIG_W-1:0] misr_fin;

   // Value the MISR will hold after the FLUSH absorption.
   assign misr_fin = misr_step(misr_sig, fsm_state_i);

   fsm_bist_misr u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_q == StInit),
      .en    ((state_q == StRun) || (state_q == StFlush)),
      .d     (fsm_state_i),
      .sig   (misr_sig)
   );

   // Sequencer FSM with registered status outputs; abort overrides start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         lfsr_q  <= Seed;
         cnt_q   <= '0;
         clr_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         clr_q  <= 1'b0;
         done_q <= 1'b0;
         if (bist_abort_i) begin
            if (state_q != StIdle) begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               pass_q  <= 1'b0;
               clr_q   <= 1'b1;
            end
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (bist_start_i) begin
                     state_q <= StInit;
                     busy_q  <= 1'b1;
                     clr_q   <= 1'b1;
                     pass_q  <= 1'b0;
                  end
               end
               StInit: begin
                  state_q <= StRun;
                  lfsr_q  <= Seed;
                  cnt_q   <= '0;
               end
               StRun: begin
                  lfsr_q <= lfsr_step(lfsr_q);
                  cnt_q  <= cnt_q + 16'd1;
                  if (cnt_q == LastPat) begin
                     state_q <= StFlush;
                  end
               end
               StFlush: begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (misr_fin == GOLDEN_SIG);
               end
               StDone: begin
                  state_q <= StIdle;
               end
               default: begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Stimulus mux: functional path when not testing, LFSR nibble in RUN.
   always_comb begin
      fsm_sig_o = '0;
      unique case (state_q)
         StIdle, StDone: fsm_sig_o = func_sig_i;
         StRun:          fsm_sig_o = lfsr_q[PAT_W-1:0];
         default:        fsm_sig_o = '0;
      endcase
   end

   assign fsm_clr_o   = clr_q | ~rst_n;
   assign bist_busy_o = busy_q;
   assign bist_done_o = done_q;
   assign bist_pass_o = pass_q;

`ifdef FSM_BIST_CTRL_SIG_READ_EN
   logic [SIG_W-1:0] sig_q;

   // Capture the final signature alongside the pass flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sig_q <= '0;
      end else if ((state_q == StFlush) && !bist_abort_i) begin
         sig_q <= misr_fin;
      end
   end

   assign bist_sig_o = sig_q;
`else
   assign bist_sig_o = '0;
`endif

endmodule

// File: tb/tb_fsm_bist_ctrl.sv
// Self-checking bench for fsm_bist_ctrl. Four instances share the control inputs:
// [0] N_PAT=1 golden 0002, [1] N_PAT=1 golden 0003, [2] N_PAT=3, [3] N_PAT=200.
// Each drives a minimal controlled FSM: clear loads state 1, otherwise state ^= stimulus.
module tb_fsm_bist_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [3:0]  func;

   logic [3:0]  st   [4];
   logic [3:0]  sig  [4];
   logic        clr  [4];
   logic        busy [4];
   logic        done [4];
   logic        pass [4];
   logic [15:0] bsig [4];

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

`ifdef FSM_BIST_CTRL_SIG_READ_EN
   localparam logic [15:0] ExpSigA = 16'h0002;
`else
   localparam logic [15:0] ExpSigA = 16'h0000;
`endif

   always #5 clk = ~clk;

   fsm_bist_ctrl #(.N_PAT(1), .LFSR_SEED(8'h01), .GOLDEN_SIG(16'h0002)) u_a (
      .clk(clk), .rst_n(rst_n), .bist_start_i(start), .bist_abort_i(abort),
      .func_sig_i(func), .fsm_state_i(st[0]), .fsm_sig_o(sig[0]), .fsm_clr_o(clr[0]),
      .bist_busy_o(busy[0]), .bist_done_o(done[0]), .bist_pass_o(pass[0]),
      .bist_sig_o(bsig[0])
   );
   fsm_bist_ctrl #(.N_PAT(1), .LFSR_SEED(8'h01), .GOLDEN_SIG(16'h0003)) u_b (
      .clk(clk), .rst_n(rst_n), .bist_start_i(start), .bist_abort_i(abort),
      .func_sig_i(func), .fsm_state_i(st[1]), .fsm_sig_o(sig[1]), .fsm_clr_o(clr[1]),
      .bist_busy_o(busy[1]), .bist_done_o(done[1]), .bist_pass_o(pass[1]),
      .bist_sig_o(bsig[1])
   );
   fsm_bist_ctrl #(.N_PAT(3), .LFSR_SEED(8'h01), .GOLDEN_SIG(16'h0000)) u_c (
      .clk(clk), .rst_n(rst_n), .bist_start_i(start), .bist_abort_i(abort),
      .func_sig_i(func), .fsm_state_i(st[2]), .fsm_sig_o(sig[2]), .fsm_clr_o(clr[2]),
      .bist_busy_o(busy[2]), .bist_done_o(done[2]), .bist_pass_o(pass[2]),
      .bist_sig_o(bsig[2])
   );
   fsm_bist_ctrl #(.N_PAT(200), .LFSR_SEED(8'h01), .GOLDEN_SIG(16'h0000)) u_d (
      .clk(clk), .rst_n(rst_n), .bist_start_i(start), .bist_abort_i(abort),
      .func_sig_i(func), .fsm_state_i(st[3]), .fsm_sig_o(sig[3]), .fsm_clr_o(clr[3]),
      .bist_busy_o(busy[3]), .bist_done_o(done[3]), .bist_pass_o(pass[3]),
      .bist_sig_o(bsig[3])
   );

   // Controlled FSM models, one per instance.
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         st[k] <= clr[k] ? 4'h1 : (st[k] ^ sig[k]);
      end
   end

   typedef struct {
      logic        start;
      logic [3:0]  func;
      logic        clr;
      logic [3:0]  sig;
      logic        busy;
      logic        done;
      logic        pass_a;
      logic        pass_b;
      logic [15:0] bsig;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int nb;
      int nd;
      logic [3:0] seq [5];

      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      func  = 4'h5;

      // Reset state.
      repeat (3) @(negedge clk);
      #1;
      chk("rst clr", 16'(clr[0]), 16'h1);
      chk("rst busy", 16'(busy[0]), 16'h0);
      chk("rst done", 16'(done[0]), 16'h0);
      chk("rst pass", 16'(pass[0]), 16'h0);
      chk("rst bsig", bsig[0], 16'h0);
      chk("rst sig", 16'(sig[0]), 16'h5);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("post-rst clr", 16'(clr[0]), 16'h0);
      chk("post-rst busy", 16'(busy[0]), 16'h0);

      // N_PAT=1 run: rows are IDLE(start), INIT, RUN, FLUSH, DONE, IDLE.
      tbl[0] = '{1'b1, 4'hA, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
      tbl[1] = '{1'b0, 4'h3, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
      tbl[2] = '{1'b0, 4'h3, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
      tbl[3] = '{1'b0, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
      tbl[4] = '{1'b0, 4'h7, 1'b0, 4'h7, 1'b0, 1'b1, 1'b1, 1'b0, ExpSigA};
      tbl[5] = '{1'b0, 4'h9, 1'b0, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0, ExpSigA};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         start = tbl[i].start;
         func  = tbl[i].func;
         #1;
         chk($sformatf("vec%0d clr", i), 16'(clr[0]), 16'(tbl[i].clr));
         chk($sformatf("vec%0d sig", i), 16'(sig[0]), 16'(tbl[i].sig));
         chk($sformatf("vec%0d busy", i), 16'(busy[0]), 16'(tbl[i].busy));
         chk($sformatf("vec%0d done", i), 16'(done[0]), 16'(tbl[i].done));
         chk($sformatf("vec%0d pass_a", i), 16'(pass[0]), 16'(tbl[i].pass_a));
         chk($sformatf("vec%0d done_b", i), 16'(done[1]), 16'(tbl[i].done));
         chk($sformatf("vec%0d pass_b", i), 16'(pass[1]), 16'(tbl[i].pass_b));
         chk($sformatf("vec%0d bsig", i), bsig[0], tbl[i].bsig);
      end

      // N_PAT=3: stimulus sequence and busy length.
      do_reset();
      func = 4'h0;
      @(negedge clk);
      start = 1'b1;
      nb = 0;
      nd = 0;
      for (int c = 0; c < 5; c++) seq[c] = 4'hF;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (busy[2]) begin
            if (nb < 5) seq[nb] = sig[2];
            nb++;
         end
         if (done[2]) nd++;
      end
      chk("n3 busy cycles", 16'(nb), 16'd5);
      chk("n3 done pulses", 16'(nd), 16'd1);
      chk("n3 init sig", 16'(seq[0]), 16'h0);
      chk("n3 run1 sig", 16'(seq[1]), 16'h1);
      chk("n3 run2 sig", 16'(seq[2]), 16'h2);
      chk("n3 run3 sig", 16'(seq[3]), 16'h4);
      chk("n3 flush sig", 16'(seq[4]), 16'h0);

      // Abort in RUN cycle 2 with N_PAT=200.
      do_reset();
      func = 4'h6;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #1;
      chk("ab run1 sig", 16'(sig[3]), 16'h1);
      @(negedge clk);
      #1;
      chk("ab run2 sig", 16'(sig[3]), 16'h2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
      chk("ab idle busy", 16'(busy[3]), 16'h0);
      chk("ab idle clr", 16'(clr[3]), 16'h1);
      chk("ab idle sig", 16'(sig[3]), 16'h6);
      chk("ab pass", 16'(pass[3]), 16'h0);
      nd = 0;
      nb = 0;
      for (int c = 0; c < 210; c++) begin
         @(negedge clk);
         #1;
         if (done[3]) nd++;
         if (busy[3]) nb++;
         if (c == 0) chk("ab clr drops", 16'(clr[3]), 16'h0);
      end
      chk("ab no done", 16'(nd), 16'd0);
      chk("ab stays idle", 16'(nb), 16'd0);

      // Start held high: one completion, then a fresh test from IDLE.
      do_reset();
      func = 4'h0;
      @(negedge clk);
      start = 1'b1;
      nd = 0;
      nb = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         #1;
         if (c <= 5 && done[0]) nd++;
         if (c <= 4 && busy[0]) nb++;
         if (c == 5) begin
            chk("hold idle busy", 16'(busy[0]), 16'h0);
            chk("hold idle pass", 16'(pass[0]), 16'h1);
         end
         if (c == 6) begin
            chk("hold restart busy", 16'(busy[0]), 16'h1);
            chk("hold restart clr", 16'(clr[0]), 16'h1);
            chk("hold restart pass", 16'(pass[0]), 16'h0);
         end
      end
      chk("hold done pulses", 16'(nd), 16'd1);
      chk("hold busy run", 16'(nb), 16'd3);
      start = 1'b0;

      // Reset asserted during RUN.
      do_reset();
      func = 4'hC;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #1;
      chk("rr run busy", 16'(busy[3]), 16'h1);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      chk("rr busy", 16'(busy[3]), 16'h0);
      chk("rr done", 16'(done[3]), 16'h0);
      chk("rr pass", 16'(pass[3]), 16'h0);
      chk("rr clr", 16'(clr[3]), 16'h1);
      chk("rr bsig", bsig[3], 16'h0);
      chk("rr sig", 16'(sig[3]), 16'hC);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("rr post clr", 16'(clr[3]), 16'h0);
      chk("rr post busy", 16'(busy[3]), 16'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
